algoritmo_correlacion: RTL and testbench
========================================

# algoritmo_correlacion

Binary sliding-window correlator for the oversampled receive path. On each clock it compares a `SAMPLES*OSF`-bit received window against a stored pattern of equal length, registers the number of agreeing bit positions as the correlation value, and raises a one-bit detection flag when the mismatch count is within a symbol-error tolerance. It sits after the sample shift register and feeds frame/pattern-detection logic downstream.

## Interface
Parameters:
- `SAMPLES`, 128: symbols per correlation window.
- `OSF`, 8: oversampling factor, in bits per symbol.
- `n`, 4: tolerated erroneous symbols. Detection threshold is `SAMPLES*OSF - n*OSF` matching bits (992 at defaults).

Ports:
- `P`, input, 1: clock. All state updates occur on its rising edge.
- `Reset`, input, 1: reset, synchronous, active-high.
- `Enable`, input, 1: update enable.
- `DataIn1`, input, `SAMPLES*OSF`: received window, as a flat bit vector. Bit i is compared with bit i of `DataIn2`.
- `DataIn2`, input, `SAMPLES*OSF`: reference pattern.
- `DataOut`, output, 1: registered detection flag.

Internal:
- Register `valorCorrelacion`, width W = `$clog2(SAMPLES*OSF+1)` (11 at defaults), unsigned.
- Must exist under exactly this name so benches can probe it hierarchically.

## Operation
- Match vector: `m = ~(DataIn1 ^ DataIn2)`.
- Correlation: `corr = popcount(m)`, range 0..`SAMPLES*OSF`.
  - Implement as a combinational adder tree.
  - Partial sums are widened at each level so no overflow is possible.
- On rising `P`, if `Reset`=1: `valorCorrelacion <= 0`, `DataOut <= 0`. Reset has priority over `Enable`.
- Else if `Enable`=1:
  - `valorCorrelacion <= corr`.
  - `DataOut <= (corr >= SAMPLES*OSF - n*OSF)`.
  - Both are computed from the same sampled inputs.
- Else: both registers hold their value.
- No state machine. The block is a stateless comparator plus one output register stage.
- `n*OSF > SAMPLES*OSF` is a parameter error. Flag it with an elaboration-time check.
- `n`=0 means only an exact match sets `DataOut`.

## Timing
- Latency: 1 clock. Inputs sampled at edge k appear on `valorCorrelacion`/`DataOut` after edge k, and are stable until edge k+1.
- Inputs must be stable around the rising edge of `P`. Benches drive `DataIn1`/`DataIn2`/`Enable` away from the rising edge (e.g. at the falling edge).
- Throughput: one new window per clock. No handshake. The caller shifts new data into `DataIn1` between edges.
- Reset values: `valorCorrelacion` = 0, `DataOut` = 0.
- Reset asserted mid-stream clears both at the next edge; the first valid result follows the first enabled edge after `Reset` drops.
- Combinational path: a 1024-input popcount in one cycle. If timing fails, pipeline internally only if `valorCorrelacion` and `DataOut` keep the same 1-cycle visible latency.

## Test plan
- Reset: `Reset`=1, `Enable`=1, arbitrary data, one edge -> `valorCorrelacion`=0, `DataOut`=0.
- Identical inputs: `DataIn1`=`DataIn2`=random 1024-bit value, `Enable`=1 -> after one edge `valorCorrelacion`=1024, `DataOut`=1.
- Complement: `DataIn1`=`~DataIn2` -> `valorCorrelacion`=0, `DataOut`=0.
- Threshold boundary:
  - exactly 32 bits differing -> 992, `DataOut`=1;
  - 33 bits differing -> 991, `DataOut`=0.
- Hold: after a result of 1024, drop `Enable`, change `DataIn1` to its complement, clock 3 edges -> value stays 1024 and `DataOut` stays 1.
- Sliding stream:
  - Load a 32-word pattern into `DataIn2`.
  - Shift 128 32-bit words into `DataIn1` (`DataIn1 = {DataIn1, word}`), one per clock.
  - Log `valorCorrelacion` in decimal after each edge and compare against a software XNOR-popcount model.
  - `DataOut`=1 exactly at the alignments where the model value is >= 992.

Source files
------------

// File: rtl/algoritmo_correlacion.sv
// -----------------------------------------------------------------------------
// algoritmo_correlacion
//
// Binary sliding-window correlator for the oversampled receive path. Every
// enabled clock it compares the received window against a stored reference
// pattern bit by bit, registers how many positions agree, and raises a
// detection flag when the number of disagreeing bits is no larger than the
// symbol-error tolerance (n symbols of OSF bits each).
//
// Parameters
//   SAMPLES : symbols per correlation window
//   OSF     : oversampling factor, bits per symbol
//   n       : tolerated erroneous symbols; detection threshold is
//             SAMPLES*OSF - n*OSF matching bits
//
// Ports
//   P        in   1            clock, rising edge active
//   Reset    in   1            synchronous active-high reset, wins over Enable
//   Enable   in   1            update enable; registers hold when low
//   DataIn1  in   SAMPLES*OSF  received window (bit i compared with bit i)
//   DataIn2  in   SAMPLES*OSF  reference pattern
//   DataOut  out  1            registered detection flag
//
// The correlation value itself lives in the internal register
// valorCorrelacion so that benches can probe it hierarchically. Both
// valorCorrelacion and DataOut appear one clock after the inputs are sampled.
// -----------------------------------------------------------------------------
module algoritmo_correlacion #(
    parameter int unsigned SAMPLES = 32'd128,
    parameter int unsigned OSF     = 32'd8,
    parameter int unsigned n       = 32'd4
) (
    input  logic                     P,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic [SAMPLES*OSF-1:0]   DataIn1,
    input  logic [SAMPLES*OSF-1:0]   DataIn2,
    output logic                     DataOut
);

    // Window length in bits and width able to hold 0..NBITS.
    localparam int unsigned NBITS = SAMPLES * OSF;
    localparam int unsigned W     = $clog2(NBITS + 32'd1);

    // The adder tree works on a power-of-two leaf count; unused leaves are
    // tied to zero so they never contribute to the count.
    localparam int unsigned LVLS  = (NBITS > 32'd1) ? $clog2(NBITS) : 32'd1;
    localparam int unsigned NPAD  = 32'd1 << LVLS;

    // Minimum number of agreeing bits that still counts as a detection.
    localparam int unsigned THRESH   = NBITS - (n * OSF);
    localparam logic [W-1:0] THRESH_W = W'(THRESH);

    // A tolerance larger than the whole window is meaningless.
    if ((n * OSF) > NBITS) begin : g_param_err
        $error("algoritmo_correlacion: n*OSF (%0d) exceeds SAMPLES*OSF (%0d)",
               n * OSF, NBITS);
    end

    logic [NPAD-1:0] match_s;
    logic [W-1:0]    corr_s;
    logic            det_s;
    logic [W-1:0]    valorCorrelacion;

    // Agreement vector: a 1 wherever received and reference bits are equal.
    always_comb begin
        match_s              = {NPAD{1'b0}};
        match_s[NBITS-1:0]   = ~(DataIn1 ^ DataIn2);
    end

    // Popcount adder tree. Level l holds NPAD>>l partial sums, each l+1 bits
    // wide: two l-bit operands are zero-extended by one bit before adding, so
    // no partial sum can overflow at any level.
    for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
        localparam int unsigned CNT = NPAD >> l;
        logic [l:0] sum_s [CNT];
        for (genvar j = 0; j < CNT; j++) begin : g_node
            if (l == 1) begin : g_leaf
                assign sum_s[j] = {1'b0, match_s[2*j]} + {1'b0, match_s[2*j+1]};
            end else begin : g_inner
                assign sum_s[j] = {1'b0, g_lvl[l-1].sum_s[2*j]}
                                + {1'b0, g_lvl[l-1].sum_s[2*j+1]};
            end
        end
    end

    // The root never exceeds NBITS, so narrowing it to W bits loses nothing.
    assign corr_s = W'(g_lvl[LVLS].sum_s[0]);

    // Detection decision taken from the same correlation that gets registered.
    always_comb begin
        if (corr_s >= THRESH_W) begin
            det_s = 1'b1;
        end else begin
            det_s = 1'b0;
        end
    end

    // Output register stage: reset clears, enable loads, otherwise hold.
    always_ff @(posedge P) begin
        if (Reset) begin
            valorCorrelacion <= {W{1'b0}};
            DataOut          <= 1'b0;
        end else if (Enable) begin
            valorCorrelacion <= corr_s;
            DataOut          <= det_s;
        end else begin
            valorCorrelacion <= valorCorrelacion;
            DataOut          <= DataOut;
        end
    end

endmodule

// File: tb/tb_algoritmo_correlacion.sv
// -----------------------------------------------------------------------------
// tb_algoritmo_correlacion
//
// Directed self-checking bench for algoritmo_correlacion at default parameters.
// Inputs change on the falling edge of P; results are read on the following
// falling edge, one rising edge after the inputs were sampled.
// -----------------------------------------------------------------------------
module tb_algoritmo_correlacion;

    localparam int unsigned SAMPLES = 128;
    localparam int unsigned OSF     = 8;
    localparam int unsigned N_ERR   = 4;
    localparam int unsigned NB      = SAMPLES * OSF;
    localparam int unsigned THRESH  = NB - N_ERR * OSF;   // 992

    logic          P = 1'b0;
    logic          Reset;
    logic          Enable;
    logic [NB-1:0] DataIn1;
    logic [NB-1:0] DataIn2;
    logic          DataOut;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 P = ~P;

    algoritmo_correlacion #(
        .SAMPLES (SAMPLES),
        .OSF     (OSF),
        .n       (N_ERR)
    ) dut (
        .P       (P),
        .Reset   (Reset),
        .Enable  (Enable),
        .DataIn1 (DataIn1),
        .DataIn2 (DataIn2),
        .DataOut (DataOut)
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for reading/driving.
    task automatic step();
        @(posedge P);
        @(negedge P);
    endtask

    function automatic logic [NB-1:0] rand_vec();
        logic [NB-1:0] v;
        for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Flip k distinct bits (positions 0, 31, 62, ...; all below 1024 for k<=33).
    function automatic logic [NB-1:0] flip_bits(input logic [NB-1:0] v, input int k);
        logic [NB-1:0] r;
        r = v;
        for (int i = 0; i < k; i++) r[i*31] = ~r[i*31];
        return r;
    endfunction

    task automatic check_out(input string tag, input int exp_corr, input logic exp_det);
        check_val({tag, "_corr"}, 32'(dut.valorCorrelacion), 32'(exp_corr));
        check_val({tag, "_det"},  32'(DataOut),              32'(exp_det));
    endtask

    logic [31:0] pat [32];
    logic [31:0] w;
    int          exp_corr;
    int          n_det;
    int          corr_at_71;
    int          corr_at_111;

    initial begin
        // Reset with enable high and arbitrary data.
        Reset   = 1'b1;
        Enable  = 1'b1;
        DataIn1 = rand_vec();
        DataIn2 = rand_vec();
        step();
        check_out("reset", 0, 1'b0);

        // Identical inputs.
        Reset   = 1'b0;
        DataIn2 = rand_vec();
        DataIn1 = DataIn2;
        step();
        check_out("identical", 1024, 1'b1);

        // Complement.
        DataIn1 = ~DataIn2;
        step();
        check_out("complement", 0, 1'b0);

        // Threshold boundary: 32 differing bits still detects, 33 does not.
        DataIn1 = flip_bits(DataIn2, 32);
        step();
        check_out("diff32", 992, 1'b1);
        DataIn1 = flip_bits(DataIn2, 33);
        step();
        check_out("diff33", 991, 1'b0);

        // Hold: load 1024, then disable and present the complement for 3 edges.
        DataIn1 = DataIn2;
        step();
        check_out("hold_load", 1024, 1'b1);
        Enable  = 1'b0;
        DataIn1 = ~DataIn2;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("hold", 1024, 1'b1);
        end

        // Reset mid-stream clears, and nothing reloads until enabled again.
        Enable  = 1'b1;
        DataIn1 = flip_bits(DataIn2, 5);
        step();
        check_out("pre_reset", 1019, 1'b1);
        Reset = 1'b1;
        step();
        check_out("mid_reset", 0, 1'b0);
        Reset  = 1'b0;
        Enable = 1'b0;
        step();
        check_out("post_reset_idle", 0, 1'b0);
        Enable = 1'b1;
        step();
        check_out("post_reset_first", 1019, 1'b1);

        // Sliding stream: the pattern appears cleanly at words 40..71 and with
        // one bit wrong per word (32 errors, exactly at threshold) at 80..111.
        for (int i = 0; i < 32; i++) pat[i] = $urandom();
        for (int i = 0; i < 32; i++) DataIn2[(31-i)*32 +: 32] = pat[i];
        DataIn1     = '0;
        n_det       = 0;
        corr_at_71  = -1;
        corr_at_111 = -1;
        for (int k = 0; k < 128; k++) begin
            if (k >= 40 && k < 72) begin
                w = pat[k-40];
            end else if (k >= 80 && k < 112) begin
                w = pat[k-80];
                w[k % 32] = ~w[k % 32];
            end else begin
                w = $urandom();
            end
            DataIn1 = {DataIn1[NB-33:0], w};
            step();
            exp_corr = $countones(~(DataIn1 ^ DataIn2));
            $display("stream word %0d: valorCorrelacion = %0d", k, dut.valorCorrelacion);
            check_val("stream_corr", 32'(dut.valorCorrelacion), 32'(exp_corr));
            check_val("stream_det", 32'(DataOut), 32'(exp_corr >= THRESH));
            if (DataOut === 1'b1) n_det++;
            if (k == 71)  corr_at_71  = int'(dut.valorCorrelacion);
            if (k == 111) corr_at_111 = int'(dut.valorCorrelacion);
        end
        check_val("stream_peak_clean", 32'(corr_at_71), 32'd1024);
        check_val("stream_peak_noisy", 32'(corr_at_111), 32'd992);
        check_val("stream_detections", 32'(n_det), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
